s08_dma_ctrl: RTL and testbench

Memory-to-memory DMA sequencer for the MiniS08 shared bus (10-bit abus, 8-bit dbus).
- CPU programs source, destination and count through a small register window.
- Block requests the bus, waits for a grant from the CPU (which grants at an instruction boundary), then moves bytes with read/write cycles on clk50.
- Raises a done flag/IRQ when the transfer completes.

---
 rtl/s08_dma_ctrl_if.sv | 32 +++
 rtl/s08_dma_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_s08_dma_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s08_dma_ctrl_if.sv
// Interface for the MiniS08 DMA sequencer: CPU register window plus shared-bus master signals.
// master = the DMA block's view, slave = the CPU/bus-fabric view.
interface s08_dma_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          cfg_sel;
  logic [2:0]    cfg_addr;
  logic          cfg_wr;
  logic          cfg_rd;
  logic [7:0]    cfg_wdata;
  logic [7:0]    cfg_rdata;
  logic          busreq;
  logic          busgnt;
  logic [AW-1:0] dma_abus;
  logic [DW-1:0] dma_dout;
  logic [DW-1:0] dma_din;
  logic          dma_read;
  logic          dma_write;
  logic          dma_oe;
  logic          done_irq;

  modport master (
    input  cfg_sel, cfg_addr, cfg_wr, cfg_rd, cfg_wdata, busgnt, dma_din,
    output cfg_rdata, busreq, dma_abus, dma_dout, dma_read, dma_write, dma_oe, done_irq
  );

  modport slave (
    output cfg_sel, cfg_addr, cfg_wr, cfg_rd, cfg_wdata, busgnt, dma_din,
    input  cfg_rdata, busreq, dma_abus, dma_dout, dma_read, dma_write, dma_oe, done_irq
  );
endinterface

// File: rtl/s08_dma_ctrl.sv
// Memory-to-memory DMA sequencer for the MiniS08 shared bus (REQ -> read -> write per byte).
// Optional constant-fill mode is compiled in with macro DMA_FILL_EN.
module s08_dma_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk50,
  input  logic           resetin,
  s08_dma_ctrl_if.master bus
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RDA, S_RDD, S_WR, S_REL
  } state_t;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_src, r_dst;
  logic [7:0]    r_cnt;
  logic [DW-1:0] r_data;
  logic [LW-1:0] r_lat;
  logic          r_inc_src, r_inc_dst;
  logic          r_done, r_aborted, r_abort_pend;

  logic          w_cfg_wr, w_ctrl_wr, w_stat_rd, w_busy, w_start, w_abort, w_fill;
  logic          w_busreq, w_oe, w_rd, w_wr, w_step, w_capture;
  logic [AW-1:0] w_abus;
  logic [DW-1:0] w_dout;
  logic [15:0]   w_src_x, w_dst_x;
  logic [7:0]    w_rdata;
  logic          w_unused;

`ifdef DMA_FILL_EN
  logic r_fill;
  assign w_fill   = r_fill;
  assign w_unused = ^{bus.cfg_wdata[7], bus.cfg_wdata[5:4]};
`else
  assign w_fill   = 1'b0;
  assign w_unused = ^{bus.cfg_wdata[7], bus.cfg_wdata[5:3]};
`endif

  assign w_cfg_wr  = bus.cfg_sel & bus.cfg_wr;
  assign w_ctrl_wr = w_cfg_wr & (bus.cfg_addr == 3'd5);
  assign w_stat_rd = bus.cfg_sel & bus.cfg_rd & (bus.cfg_addr == 3'd5);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_ctrl_wr & bus.cfg_wdata[0] & ~w_busy;
  // An abort written this very cycle counts, so REQ can bail out without waiting a clock.
  assign w_abort   = r_abort_pend | (w_ctrl_wr & bus.cfg_wdata[6]);

  always_comb begin
    w_state_next = r_state;
    w_busreq     = 1'b0;
    w_oe         = 1'b0;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_abus       = '0;
    w_dout       = '0;
    w_step       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_busreq = 1'b1;
        if (w_abort)         w_state_next = S_REL;
        else if (bus.busgnt) w_state_next = w_fill ? S_WR : S_RDA;
      end
      S_RDA, S_RDD: begin
        w_busreq = 1'b1;
        if (!bus.busgnt) begin
          w_state_next = S_REQ;
        end else begin
          w_oe   = 1'b1;
          w_rd   = 1'b1;
          w_abus = r_src;
          if (r_state == S_RDA) begin
            w_state_next = S_RDD;
          end else if (r_lat == LW'(RD_LAT - 1)) begin
            w_capture    = 1'b1;
            w_state_next = S_WR;
          end
        end
      end
      S_WR: begin
        w_busreq = 1'b1;
        if (!bus.busgnt) begin
          w_state_next = S_REQ;
        end else begin
          w_oe   = 1'b1;
          w_wr   = 1'b1;
          w_abus = r_dst;
          w_dout = w_fill ? r_src[DW-1:0] : r_data;
          w_step = 1'b1;
          if (r_cnt == 8'd1 || w_abort) w_state_next = S_REL;
          else                          w_state_next = w_fill ? S_WR : S_RDA;
        end
      end
      S_REL:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!resetin) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_lat        <= '0;
      r_inc_src    <= 1'b0;
      r_inc_dst    <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (r_state == S_RDD && w_state_next == S_RDD) r_lat <= r_lat + 1'b1;
      else                                           r_lat <= '0;
      if (w_capture) r_data <= bus.dma_din;

      if (w_cfg_wr && !w_busy) begin
        case (bus.cfg_addr)
          3'd0: r_src[AW-1:8] <= bus.cfg_wdata[AW-9:0];
          3'd1: r_src[7:0]    <= bus.cfg_wdata;
          3'd2: r_dst[AW-1:8] <= bus.cfg_wdata[AW-9:0];
          3'd3: r_dst[7:0]    <= bus.cfg_wdata;
          3'd4: r_cnt         <= bus.cfg_wdata;
          3'd5: begin
            r_inc_src <= bus.cfg_wdata[1];
            r_inc_dst <= bus.cfg_wdata[2];
`ifdef DMA_FILL_EN
            r_fill    <= bus.cfg_wdata[3];
`endif
          end
          default: ;
        endcase
      end

      // Fill mode keeps SRC fixed because SRCL is the constant being written.
      if (w_step) begin
        r_src <= r_src + AW'(r_inc_src & ~w_fill);
        r_dst <= r_dst + AW'(r_inc_dst);
        r_cnt <= r_cnt - 8'd1;
      end

      if (!w_busy || r_state == S_REL)       r_abort_pend <= 1'b0;
      else if (w_ctrl_wr && bus.cfg_wdata[6]) r_abort_pend <= 1'b1;

      if (w_stat_rd) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (r_state == S_REL) begin
        r_done <= 1'b1;
        if (r_abort_pend) r_aborted <= 1'b1;
      end
    end
  end

  assign w_src_x = 16'(r_src);
  assign w_dst_x = 16'(r_dst);

  always_comb begin
    w_rdata = 8'h00;
    case (bus.cfg_addr)
      3'd0:    w_rdata = w_src_x[15:8];
      3'd1:    w_rdata = r_src[7:0];
      3'd2:    w_rdata = w_dst_x[15:8];
      3'd3:    w_rdata = r_dst[7:0];
      3'd4:    w_rdata = r_cnt;
      3'd5:    w_rdata = {r_aborted, 3'b000, w_fill, r_inc_src, r_done, w_busy};
      default: w_rdata = 8'h00;
    endcase
  end

  assign bus.cfg_rdata = w_rdata;
  assign bus.busreq    = w_busreq;
  assign bus.dma_oe    = w_oe;
  assign bus.dma_read  = w_rd;
  assign bus.dma_write = w_wr;
  assign bus.dma_abus  = w_abus;
  assign bus.dma_dout  = w_dout;
  assign bus.done_irq  = r_done;

endmodule

// File: tb/tb_s08_dma_ctrl.sv
// Self-checking bench for s08_dma_ctrl: transaction-level copy/fill model, bus RAM model, per-cycle monitor.
module tb_s08_dma_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
`ifdef DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  typedef struct {
    int rd;
    int wr;
    int dat;
  } xfer_t;

  logic clk50 = 1'b0;
  logic resetin = 1'b0;
  always #5 clk50 = ~clk50;

  s08_dma_ctrl_if #(.AW(AW), .DW(DW)) bus_if ();
  s08_dma_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk50  (clk50),
    .resetin(resetin),
    .bus    (bus_if)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [1024];
  logic [7:0] din_q = 8'h00;
  xfer_t exp_q[$];
  bit fill_mode = 1'b0;
  bit mon_en = 1'b0;
  bit model_done = 1'b0;
  int writes_seen = 0;

  // Synchronous RAM/ROM on the shared bus: one clock read latency.
  assign bus_if.dma_din = din_q;
  always @(posedge clk50) begin
    if (bus_if.dma_write) mem[bus_if.dma_abus] <= bus_if.dma_dout;
    din_q <= mem[bus_if.dma_abus];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle bus monitor against the expected transaction queue.
  always @(negedge clk50) begin
    if (mon_en) begin
      if (!bus_if.dma_oe)
        chk("idle_bus", {bus_if.dma_abus, bus_if.dma_read, bus_if.dma_write}, 32'd0);
      else
        chk("busreq_own", bus_if.busreq, 32'd1);
      if (!bus_if.busgnt)
        chk("strobe_wo_gnt", {bus_if.dma_read, bus_if.dma_write}, 32'd0);
      if (bus_if.dma_read) begin
        if (fill_mode || exp_q.size() == 0) chk("unexpected_read", bus_if.dma_read, 32'd0);
        else                                chk("rd_addr", bus_if.dma_abus, exp_q[0].rd);
      end
      if (bus_if.dma_write) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", bus_if.dma_write, 32'd0);
        end else begin
          chk("wr_addr", bus_if.dma_abus, exp_q[0].wr);
          chk("wr_data", bus_if.dma_dout, exp_q[0].dat);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    bus_if.cfg_sel = 1'b1; bus_if.cfg_wr = 1'b1; bus_if.cfg_addr = a; bus_if.cfg_wdata = d;
    tick();
    bus_if.cfg_sel = 1'b0; bus_if.cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
    bus_if.cfg_sel = 1'b1; bus_if.cfg_rd = 1'b1; bus_if.cfg_addr = a;
    @(negedge clk50);
    d = bus_if.cfg_rdata;
    tick();
    bus_if.cfg_sel = 1'b0; bus_if.cfg_rd = 1'b0;
  endtask

  // Byte-by-byte copy semantics on a snapshot of memory, so overlapping regions resolve as the spec's sequence.
  task automatic build_queue(input int src, input int dst, input int cnt, input bit is, input bit id,
                             input bit fl, input int nexp);
    logic [7:0] ref_mem [1024];
    int n, s, d, v;
    xfer_t x;
    ref_mem = mem;
    exp_q.delete();
    writes_seen = 0;
    n = (cnt == 0) ? 256 : cnt;
    for (int k = 0; k < n; k++) begin
      s = fl ? src : (src + k * is) % 1024;
      d = (dst + k * id) % 1024;
      v = fl ? (src & 255) : int'(ref_mem[s]);
      ref_mem[d] = 8'(v);
      x.rd = fl ? -1 : s; x.wr = d; x.dat = v;
      if (k < nexp) exp_q.push_back(x);
    end
  endtask

  // script: 0 grant tied 1, 1 random grant, 2 scripted grant handshake, 3 abort at cycle 7, 4 reset at cycle 6
  task automatic run(input int src, input int dst, input int cnt, input bit is, input bit id, input bit fl,
                     input int script, input int exp_busy, input int nexp);
    int busy, cyc;
    bit fl_eff;
    fl_eff = fl & FILL_ON;
    build_queue(src, dst, cnt, is, id, fl_eff, nexp);
    fill_mode = fl_eff;
    cfg_write(3'd0, 8'(src >> 8));
    cfg_write(3'd1, 8'(src));
    cfg_write(3'd2, 8'(dst >> 8));
    cfg_write(3'd3, 8'(dst));
    cfg_write(3'd4, 8'(cnt));
    cfg_write(3'd5, {4'b0000, fl, id, is, 1'b1});
    bus_if.cfg_addr = 3'd5;
    busy = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      case (script)
        1: bus_if.busgnt = ($urandom_range(0, 3) != 0);
        2: bus_if.busgnt = !(cyc < 5 || cyc == 10);
        3: begin
          bus_if.cfg_sel = (cyc == 7); bus_if.cfg_wr = (cyc == 7); bus_if.cfg_wdata = 8'h40;
        end
        4: resetin = (cyc != 6);
        default: bus_if.busgnt = 1'b1;
      endcase
      @(negedge clk50);
      if (cyc == 0) chk("done_hold", bus_if.done_irq, model_done);
      if (!bus_if.cfg_rdata[0]) break;
      busy++;
      tick();
    end
    if (cyc >= 4000) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=%0d required=<4000", cyc);
    end
    tick();
    bus_if.cfg_sel = 1'b0; bus_if.cfg_wr = 1'b0; bus_if.busgnt = 1'b1; resetin = 1'b1;
    if (exp_busy >= 0) chk("busy_cycles", busy, exp_busy);
    chk("queue_left", exp_q.size(), 0);
    chk("bytes_written", writes_seen, nexp);
    model_done = (script != 4);
    fill_mode = 1'b0;
  endtask

  task automatic check_regs(input int src_e, input int dst_e, input int cnt_e, input logic [7:0] stat_e,
                            input bit read_stat);
    logic [7:0] v;
    cfg_read(3'd0, v); chk("srch", v, (src_e >> 8) & 3);
    cfg_read(3'd1, v); chk("srcl", v, src_e & 255);
    cfg_read(3'd2, v); chk("dsth", v, (dst_e >> 8) & 3);
    cfg_read(3'd3, v); chk("dstl", v, dst_e & 255);
    cfg_read(3'd4, v); chk("cnt", v, cnt_e & 255);
    chk("done_irq", bus_if.done_irq, model_done);
    if (read_stat) begin
      cfg_read(3'd5, v); chk("stat", v, stat_e);
      cfg_read(3'd5, v); chk("stat_clr", v, stat_e & 8'h7D);
      chk("irq_clr", bus_if.done_irq, 32'd0);
      model_done = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] v;
    int s, d, c, n;
    bit is, id, fl;
    bus_if.cfg_sel = 1'b0; bus_if.cfg_wr = 1'b0; bus_if.cfg_rd = 1'b0;
    bus_if.cfg_addr = 3'd0; bus_if.cfg_wdata = 8'h00; bus_if.busgnt = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    @(negedge clk50);
    chk("rst_outputs", {bus_if.busreq, bus_if.dma_oe, bus_if.dma_read, bus_if.dma_write,
                        bus_if.dma_abus, bus_if.done_irq}, 32'd0);
    tick();
    resetin = 1'b1;
    mon_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      cfg_read(3'(a), v); chk("rst_reg", v, 32'd0);
    end
    cfg_write(3'd6, 8'hFF);
    cfg_read(3'd6, v); chk("reg6_zero", v, 32'd0);

    // ROM to RAM copy: 1 REQ + 4*3 + 1 REL busy cycles.
    run(32'h1B5, 32'h020, 4, 1'b1, 1'b1, 1'b0, 0, 14, 4);
    check_regs(32'h1B9, 32'h024, 0, 8'h06, 1'b1);

    // 256-byte transfer, destination wraps through 0x3FF.
    run(32'h100, 32'h3FE, 0, 1'b0, 1'b1, 1'b0, 0, 770, 256);
    check_regs(32'h100, 32'h0FE, 0, 8'h02, 1'b1);

    // Grant withheld 5 cycles, then lost for the RDD of byte 2.
    run(32'h2F0, 32'h300, 4, 1'b1, 1'b1, 1'b0, 2, 22, 4);
    check_regs(32'h2F4, 32'h304, 0, 8'h06, 1'b1);

    // Abort during byte 3 RDA: byte 3 finishes, nothing after.
    run(32'h050, 32'h200, 10, 1'b1, 1'b1, 1'b0, 3, 11, 3);
    check_regs(32'h053, 32'h203, 7, 8'h86, 1'b1);

    // Reset during WR of byte 2.
    run(32'h080, 32'h180, 5, 1'b1, 1'b1, 1'b0, 4, 7, 2);
    exp_q.delete();
    @(negedge clk50);
    chk("rst_mid_out", {bus_if.busreq, bus_if.dma_oe, bus_if.dma_read, bus_if.dma_write,
                        bus_if.dma_abus, bus_if.done_irq}, 32'd0);
    tick();
    for (int a = 0; a < 6; a++) begin
      cfg_read(3'(a), v); chk("rst_mid_reg", v, 32'd0);
    end
    repeat (10) tick();

`ifdef DMA_FILL_EN
    run(32'h0A5, 32'h040, 3, 1'b0, 1'b1, 1'b1, 0, 5, 3);
    check_regs(32'h0A5, 32'h043, 0, 8'h0A, 1'b1);
`endif

    // Random transfers with random grant; even ones leave done set so the next start sees it held.
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 1023); d = $urandom_range(0, 1023); c = $urandom_range(1, 12);
      is = 1'($urandom); id = 1'($urandom); fl = 1'($urandom);
      n = c;
      run(s, d, c, is, id, fl, 1, -1, n);
      check_regs((fl & FILL_ON) ? s : (s + n * is) % 1024, (d + n * id) % 1024, 0,
                 {4'b0000, fl & FILL_ON, is, 1'b1, 1'b0}, (i % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
